// File: rtl/ip2_scanout_rx.sv
// Scan-chain readout receiver: samples scan_out at a bxclk phase, packs bits LSB-first into words.
// Optional trailing even-parity check enabled by defining IP2_SCANOUT_RX_PARITY_EN.
//   state      | meaning
//   IDLE       | waiting for start
//   WAIT_SHIFT | capture armed, waiting for scan chain to enter shift mode
//   SAMPLE     | capturing one bit per matching sample event
//   FLUSH      | all bits captured, draining final word
//   DONE       | one-cycle completion, raises status_done
module ip2_scanout_rx #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [5:0]        clk_counter,
  input  logic [5:0]        sample_phase,
  input  logic              start,
  input  logic [10:0]       bit_cnt_max,
  input  logic              scan_load_i,
  input  logic              scan_out_i,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last,
  output logic [10:0]       bit_cnt,
  output logic              status_done,
  output logic              status_overrun,
`ifdef IP2_SCANOUT_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic [2:0]        state
);

  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SHIFT = 3'd1,
    SAMPLE     = 3'd2,
    FLUSH      = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] stage_q, stage_d;
  logic              stage_last_q, stage_last_d;
  logic              xfer_q, xfer_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              wvalid_q, wvalid_d;
  logic              wlast_q, wlast_d;
  logic              last_held_q, last_held_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              rdy_q;
`ifdef IP2_SCANOUT_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  logic              sample_ev;
  logic              start_ok;
  logic              is_data;
  logic [10:0]       cnt_inc;
  logic [10:0]       data_max;
  logic [WORD_W-1:0] asm_nx;

  // With parity enabled the last counted bit is the parity bit and never lands in a word.
`ifdef IP2_SCANOUT_RX_PARITY_EN
  assign data_max = (bit_cnt_max == 11'd0) ? 11'd0 : bit_cnt_max - 11'd1;
`else
  assign data_max = bit_cnt_max;
`endif

  assign start_ok  = start && rdy_q && enable;
  assign sample_ev = (state_q == SAMPLE) && (clk_counter == sample_phase) &&
                     !scan_load_i && (bit_cnt_q < bit_cnt_max);
  assign cnt_inc   = bit_cnt_q + 11'd1;
  assign is_data   = bit_cnt_q < data_max;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    widx_d       = widx_q;
    asm_d        = asm_q;
    stage_d      = stage_q;
    stage_last_d = stage_last_q;
    xfer_d       = 1'b0;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    wlast_d      = wlast_q;
    last_held_d  = last_held_q;
    done_d       = done_q;
    ovr_d        = ovr_q;
    asm_nx       = asm_q;
`ifdef IP2_SCANOUT_RX_PARITY_EN
    par_d        = par_q;
    perr_d       = perr_q;
`endif

    if (wvalid_q && word_ready) begin
      wvalid_d    = 1'b0;
      last_held_d = 1'b0;
    end
    if (xfer_q) begin
      if (!wvalid_q || word_ready) begin
        wdata_d     = stage_q;
        wlast_d     = stage_last_q;
        wvalid_d    = 1'b1;
        last_held_d = stage_last_q;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          bit_cnt_d = '0;
          widx_d    = '0;
          asm_d     = '0;
          done_d    = 1'b0;
          ovr_d     = 1'b0;
`ifdef IP2_SCANOUT_RX_PARITY_EN
          par_d     = 1'b0;
          perr_d    = 1'b0;
`endif
          state_d   = (bit_cnt_max == 11'd0) ? DONE : WAIT_SHIFT;
        end
      end
      WAIT_SHIFT: begin
        if (!scan_load_i) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (sample_ev) begin
          bit_cnt_d = cnt_inc;
`ifdef IP2_SCANOUT_RX_PARITY_EN
          par_d     = par_q ^ scan_out_i;
`endif
          if (is_data) begin
            asm_nx[widx_q] = scan_out_i;
            if ((widx_q == IW'(WORD_W - 1)) || (cnt_inc == data_max)) begin
              stage_d      = asm_nx;
              stage_last_d = (cnt_inc == data_max);
              xfer_d       = 1'b1;
              asm_d        = '0;
              widx_d       = '0;
            end else begin
              asm_d  = asm_nx;
              widx_d = widx_q + 1'b1;
            end
          end
          if (cnt_inc == bit_cnt_max) state_d = FLUSH;
        end else if (bit_cnt_q >= bit_cnt_max) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!xfer_q && (!last_held_q || word_ready)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
`ifdef IP2_SCANOUT_RX_PARITY_EN
        perr_d  = perr_q | par_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable abandons the capture but keeps the sticky status for software.
    if (!enable) begin
      state_d     = IDLE;
      wvalid_d    = 1'b0;
      xfer_d      = 1'b0;
      asm_d       = '0;
      widx_d      = '0;
      last_held_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      widx_q       <= '0;
      asm_q        <= '0;
      stage_q      <= '0;
      stage_last_q <= 1'b0;
      xfer_q       <= 1'b0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      last_held_q  <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
      rdy_q        <= 1'b0;
`ifdef IP2_SCANOUT_RX_PARITY_EN
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      widx_q       <= widx_d;
      asm_q        <= asm_d;
      stage_q      <= stage_d;
      stage_last_q <= stage_last_d;
      xfer_q       <= xfer_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      last_held_q  <= last_held_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
      rdy_q        <= 1'b1;
`ifdef IP2_SCANOUT_RX_PARITY_EN
      par_q        <= par_d;
      perr_q       <= perr_d;
`endif
    end
  end

  assign word_data      = wdata_q;
  assign word_valid     = wvalid_q;
  assign word_last      = wlast_q;
  assign bit_cnt        = bit_cnt_q;
  assign status_done    = done_q;
  assign status_overrun = ovr_q;
  assign state          = state_q;
`ifdef IP2_SCANOUT_RX_PARITY_EN
  assign parity_err     = perr_q;
`endif

endmodule

// File: doc/ip2_scanout_rx.md
IP2_SCANOUT_RX -- requirements
Module: ip2_scanout_rx

Interface
REQ-001 Parameter WORD_W, default 32, output word width.
REQ-002 clk  in  1  FM clock 400 MHz (pl_clk1); all logic on its rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-high.
REQ-004 enable  in  1  block select; low forces IDLE synchronously.
REQ-005 clk_counter  in  6  free-running bxclk phase counter.
REQ-006 sample_phase  in  6  clk_counter value at which scan_out is sampled.
REQ-007 start  in  1  single-cycle pulse launching one capture.
REQ-008 bit_cnt_max  in  11  number of bits to capture (0..1536).
REQ-009 scan_load_i  in  1  scan-chain mode as driven to ASIC (LOW=shift, HIGH=load-comp).
REQ-010 scan_out_i  in  1  serial data from ASIC scan chain.
REQ-011 word_ready  in  1  downstream accepts word.
REQ-012 word_data  out  WORD_W  captured word; stream bit n at word n/WORD_W, bit n%WORD_W.
REQ-013 word_valid  out  1  word_data valid; held until word_ready.
REQ-014 word_last  out  1  marks final word of capture, qualified by word_valid.
REQ-015 bit_cnt  out  11  bits captured so far.
REQ-016 status_done  out  1  capture complete, sticky until next start.
REQ-017 status_overrun  out  1  word lost, sticky until next start.
REQ-018 state  out  3  current state encoding.

Function
REQ-019 States: IDLE, WAIT_SHIFT, SAMPLE, FLUSH, DONE.
REQ-020 IDLE -> WAIT_SHIFT on start; start outside IDLE ignored; start clears bit_cnt, status_done, status_overrun, assembly register.
REQ-021 start with bit_cnt_max==0 -> DONE directly, no word emitted.
REQ-022 WAIT_SHIFT -> SAMPLE on first cycle scan_load_i==0.
REQ-023 SAMPLE: when clk_counter==sample_phase and scan_load_i==0, write scan_out_i into assembly bit bit_cnt%WORD_W, increment bit_cnt next cycle.
REQ-024 Sample events with scan_load_i==1 are skipped; bit_cnt unchanged.
REQ-025 Assembly word complete (bit_cnt%WORD_W reaches 0 after increment) or final bit captured -> transfer to output register the following cycle; unwritten upper bits are 0.
REQ-026 word_valid asserts one clk after transfer; word_data/word_last stable while word_valid and not word_ready.
REQ-027 Transfer completes on word_valid & word_ready; word_valid drops next cycle unless a new word is transferred in that same cycle (back-to-back allowed).
REQ-028 Transfer while output register full and no word_ready -> new word discarded, status_overrun=1, capture continues.
REQ-029 bit_cnt==bit_cnt_max after final sample -> FLUSH; FLUSH -> DONE once last word accepted or discarded.
REQ-030 DONE sets status_done=1, next cycle -> IDLE.
REQ-031 bit_cnt saturates at bit_cnt_max; no wrap.
REQ-032 enable low mid-capture: next cycle state=IDLE, word_valid=0, status flags retained, partial word discarded.

Reset
REQ-033 reset asynchronously forces state=IDLE, word_data=0, word_valid=0, word_last=0, bit_cnt=0, status_done=0, status_overrun=0.
REQ-034 Reset release takes effect at first clk edge after deassertion; no start honoured that edge.

Configuration
REQ-035 Macro IP2_SCANOUT_RX_PARITY_EN defined: extra output parity_err (1 bit); bit_cnt_max counts data bits plus one trailing even-parity bit; parity bit not written to any word; parity_err sticky, set in DONE if XOR of all bits incl. parity is 1, cleared by start/reset.
REQ-036 Macro undefined: no parity_err port; all bit_cnt_max bits are data.

Verification
REQ-037 WORD_W=32, bit_cnt_max=64, scan_out pattern 0xA5A5_0F0F,0x1234_5678 LSB-first, ready=1 -> two words equal pattern, word_last on second, status_done=1.
REQ-038 bit_cnt_max=40, all-ones -> words 0xFFFF_FFFF then 0x0000_00FF with word_last.
REQ-039 word_ready=0 throughout, bit_cnt_max=96 -> first word held valid, status_overrun=1, DONE reached.
REQ-040 scan_load_i high for 3 sample events mid-stream, bit_cnt_max=32 -> those samples skipped, word contains 32 shift-mode bits only.
REQ-041 reset asserted mid-capture at bit_cnt=17 -> all outputs zero immediately, IDLE; new start captures cleanly.
REQ-042 PARITY_EN, bit_cnt_max=33, data 0x0000_0001, parity bit 0 -> word 0x0000_0001, parity_err=1; parity bit 1 -> parity_err=0.
